// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single subtractor cell
// with a registered borrow. start/busy/done handshake; results held until the next op.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CntW-1:0]  cnt_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;

    logic x;
    logic y;
    logic dbit;
    logic nb;

    always_comb begin
        x    = sa_q[0];
        y    = sb_q[0];
        dbit = x ^ y ^ borrow_q;
        nb   = (~x & y) | (~(x ^ y) & borrow_q);
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sr_d = {dbit, sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sa_q         <= '0;
            sb_q         <= '0;
            sr_q         <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    sr_q     <= sr_d;
                    borrow_q <= nb;
                    if (cnt_q == LastCnt) begin
                        cnt_q        <= '0;
                        diff_q       <= sr_d;
                        borrow_out_q <= nb;
                        done_q       <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor (WIDTH=8): results, latency,
// done pulse width, result hold, ignored starts and mid-run reset.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count done pulses over a window where none may appear.
    task automatic watch_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done !== 1'b0) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    // mode 0: plain op; 1: start pulse during RUN; 2: start pulse during DONE.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input int mode);
        int         edges;
        bit         held;
        logic [7:0] prev;
        prev = diff;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        check({tag, " busy_run"}, busy, 1);
        edges = 0;
        held  = 1'b1;
        while (done !== 1'b1 && edges < WIDTH + 6) begin
            if (diff !== prev) held = 1'b0;
            if (mode == 1 && edges == 3) begin
                start = 1'b1;
                a     = 8'h00;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check({tag, " latency"}, edges, WIDTH);
        check({tag, " done"}, done, 1);
        check({tag, " diff"}, diff, ed);
        check({tag, " borrow"}, borrow_out, eb);
        check({tag, " busy_done"}, busy, 1);
        check({tag, " hold"}, held, 1);
        if (mode == 2) begin
            start = 1'b1;
            a     = 8'h55;
            b     = 8'h11;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_width"}, done, 0);
        check({tag, " busy_idle"}, busy, 0);
        check({tag, " diff_held"}, diff, ed);
        if (mode != 0) watch_quiet({tag, " no_extra_done"}, WIDTH + 4);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst diff", diff, 0);
        check("rst borrow", borrow_out, 0);
        rst_n = 1'b1;

        run_op("t1 05-03", 8'h05, 8'h03, 8'h02, 1'b0, 0);
        run_op("t2 03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 0);
        run_op("t3 00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 0);
        run_op("t3 FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 0);
        run_op("t4 80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1);
        run_op("done_poke A5-5A", 8'hA5, 8'h5A, 8'h4B, 1'b0, 2);
        run_op("5A-A5", 8'h5A, 8'hA5, 8'hB5, 1'b1, 0);
        run_op("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 0);
        run_op("7F-80", 8'h7F, 8'h80, 8'hFF, 1'b1, 0);
        run_op("FF-00", 8'hFF, 8'h00, 8'hFF, 1'b0, 0);
        run_op("01-80", 8'h01, 8'h80, 8'h81, 1'b1, 0);
        run_op("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 0);

        // Mid-run reset aborts the operation and clears the outputs.
        run_op("t5 05-03", 8'h05, 8'h03, 8'h02, 1'b0, 0);
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5 busy", busy, 0);
        check("t5 done", done, 0);
        check("t5 diff", diff, 0);
        check("t5 borrow", borrow_out, 0);
        rst_n = 1'b1;
        watch_quiet("t5 no_done", WIDTH + 4);
        run_op("t5 recover 03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 0);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("rand", ra, rb, 8'(ra - rb), (ra < rb), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
